// File: rtl/eqclk_pkg.sv
// ============================================================
// eqclk_pkg : phase type and E/Q encoding for eq_clock_gen
// Rev 1.0
// ============================================================
`default_nettype none

package eqclk_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  // {E, Q} levels for each quarter phase; Q leads E by one quarter.
  localparam logic [1:0] EQ_P0 = 2'b00;
  localparam logic [1:0] EQ_P1 = 2'b01;
  localparam logic [1:0] EQ_P2 = 2'b11;
  localparam logic [1:0] EQ_P3 = 2'b10;

  function automatic logic [1:0] eq_of(input phase_t p);
    case (p)
      P0:      eq_of = EQ_P0;
      P1:      eq_of = EQ_P1;
      P2:      eq_of = EQ_P2;
      P3:      eq_of = EQ_P3;
      default: eq_of = EQ_P0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/eq_clock_gen_wait_sync.sv
// ============================================================
// wait_sync : per-bit double-flop synchronizer, resets to all-ones
// Rev 1.0
// ============================================================
`default_nettype none

module wait_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Reset to idle (no wait request) so a reset never produces a stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/eq_clock_gen.sv
// ============================================================
// eq_clock_gen : 6809/6309 E/Q quadrature clock with wait-state stretching
// Optional EQCLK_WAIT_SYNC_EN: nWAIT passes a 2-flop synchronizer. Rev 1.0
// ============================================================
`default_nettype none

module eq_clock_gen
  import eqclk_pkg::*;
#(
  parameter int QUARTER     = 4,
  parameter int N_WAIT      = 2,
  parameter int MAX_STRETCH = 8
) (
  input  logic              MHZ48,
  input  logic              nRESET,
  input  logic [N_WAIT-1:0] nWAIT,
  output logic              MHZ12,
  output logic              nQ,
  output logic              nE,
  output logic              CYCSTART,
  output logic              STRETCHING,
  output logic              WAITTO
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int SW = $clog2(MAX_STRETCH + 1);
  localparam logic [QW-1:0] QCNT_TC  = QW'(QUARTER - 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(MAX_STRETCH);

  logic [N_WAIT-1:0] nwait_s;
  logic              wait_req;

`ifdef EQCLK_WAIT_SYNC_EN
  wait_sync #(
    .W (N_WAIT)
  ) u_wait_sync (
    .clk   (MHZ48),
    .rst_n (nRESET),
    .d     (nWAIT),
    .q     (nwait_s)
  );
`else
  assign nwait_s = nWAIT;
`endif

  assign wait_req = ~&nwait_s;

  phase_t          phase_q, phase_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [1:0]      div_q, div_d;
  logic            nq_q, nq_d;
  logic            ne_q, ne_d;
  logic            cycstart_q, cycstart_d;
  logic            stretching_q, stretching_d;
  logic            waitto_q, waitto_d;
  logic            started_q, started_d;
  logic [1:0]      eq_d;
  logic            tc;

  assign tc = (qcnt_q == QCNT_TC);

  always_comb begin
    phase_d    = phase_q;
    qcnt_d     = qcnt_q + 1'b1;
    scnt_d     = scnt_q;
    div_d      = div_q + 2'd1;
    started_d  = 1'b1;
    // The first cycle out of reset is announced as a new bus cycle.
    cycstart_d = ~started_q;
    waitto_d   = 1'b0;

    if (tc) begin
      qcnt_d = '0;
      case (phase_q)
        P0: phase_d = P1;
        P1: phase_d = P2;
        P2: phase_d = P3;
        P3: begin
          if (wait_req && (scnt_q != SCNT_MAX)) begin
            scnt_d = scnt_q + 1'b1;
          end else begin
            phase_d    = P0;
            scnt_d     = '0;
            cycstart_d = 1'b1;
            waitto_d   = wait_req;
          end
        end
        default: phase_d = P0;
      endcase
    end

    eq_d         = eq_of(phase_d);
    ne_d         = ~eq_d[1];
    nq_d         = ~eq_d[0];
    stretching_d = (scnt_d != '0);
  end

  always_ff @(posedge MHZ48 or negedge nRESET) begin
    if (!nRESET) begin
      phase_q      <= P0;
      qcnt_q       <= '0;
      scnt_q       <= '0;
      div_q        <= '0;
      nq_q         <= 1'b1;
      ne_q         <= 1'b1;
      cycstart_q   <= 1'b0;
      stretching_q <= 1'b0;
      waitto_q     <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      qcnt_q       <= qcnt_d;
      scnt_q       <= scnt_d;
      div_q        <= div_d;
      nq_q         <= nq_d;
      ne_q         <= ne_d;
      cycstart_q   <= cycstart_d;
      stretching_q <= stretching_d;
      waitto_q     <= waitto_d;
      started_q    <= started_d;
    end
  end

  assign MHZ12      = div_q[1];
  assign nQ         = nq_q;
  assign nE         = ne_q;
  assign CYCSTART   = cycstart_q;
  assign STRETCHING = stretching_q;
  assign WAITTO     = waitto_q;

endmodule

`default_nettype wire

// File: tb/tb_eq_clock_gen.sv
// ============================================================
// tb_eq_clock_gen : directed + random checks of eq_clock_gen vs position model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_eq_clock_gen;

  localparam int QUARTER     = 4;
  localparam int N_WAIT      = 2;
  localparam int MAX_STRETCH = 8;
  localparam int HALF        = 5;

  logic              MHZ48  = 1'b0;
  logic              nRESET = 1'b1;
  logic [N_WAIT-1:0] nWAIT  = '1;
  logic              MHZ12, nQ, nE, CYCSTART, STRETCHING, WAITTO;

  eq_clock_gen #(
    .QUARTER     (QUARTER),
    .N_WAIT      (N_WAIT),
    .MAX_STRETCH (MAX_STRETCH)
  ) dut (
    .MHZ48      (MHZ48),
    .nRESET     (nRESET),
    .nWAIT      (nWAIT),
    .MHZ12      (MHZ12),
    .nQ         (nQ),
    .nE         (nE),
    .CYCSTART   (CYCSTART),
    .STRETCHING (STRETCHING),
    .WAITTO     (WAITTO)
  );

  always #HALF MHZ48 = ~MHZ48;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: position inside the current E cycle, in MHZ48 cycles.
  int                pos;
  int                edges;
  bit                started;
  bit                m_cyc;
  bit                m_wto;
  logic [N_WAIT-1:0] s1, s2;

  int   rel;
  int   e_rise[$], e_fall[$], q_rise[$], q_fall[$], m_rise[$], cys_q[$];
  int   str_cnt, wto_cnt;
  logic p_e, p_q, p_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos     = 0;
    edges   = 0;
    started = 1'b0;
    m_cyc   = 1'b0;
    m_wto   = 1'b0;
    s1      = '1;
    s2      = '1;
  endtask

  task automatic model_edge();
    logic [N_WAIT-1:0] seen;
    bit                req;
    int                qtr;
`ifdef EQCLK_WAIT_SYNC_EN
    seen = s2;
    s2   = s1;
    s1   = nWAIT;
`else
    seen = nWAIT;
`endif
    req     = (seen != '1);
    m_cyc   = !started;
    started = 1'b1;
    m_wto   = 1'b0;
    qtr     = pos / QUARTER;
    // End of a P3 quarter: qtr-3 quarters have already been inserted.
    if (((pos + 1) % QUARTER == 0) && (qtr >= 3)) begin
      if (req && ((qtr - 3) < MAX_STRETCH)) begin
        pos++;
      end else begin
        m_wto = req;
        m_cyc = 1'b1;
        pos   = 0;
      end
    end else begin
      pos++;
    end
    edges++;
  endtask

  task automatic compare();
    int         qtr;
    logic [5:0] exp;
    qtr = pos / QUARTER;
    exp = {((edges % 4) >= 2), !((qtr == 1) || (qtr == 2)), !(qtr >= 2),
           m_cyc, (qtr >= 4), m_wto};
    chk6("outputs{MHZ12,nQ,nE,CYCSTART,STRETCHING,WAITTO}",
         {MHZ12, nQ, nE, CYCSTART, STRETCHING, WAITTO}, exp);
  endtask

  task automatic clr_stats();
    rel = 0;
    e_rise.delete(); e_fall.delete(); q_rise.delete(); q_fall.delete();
    m_rise.delete(); cys_q.delete();
    str_cnt = 0;
    wto_cnt = 0;
    p_e = ~nE;
    p_q = ~nQ;
    p_m = MHZ12;
  endtask

  task automatic step();
    @(posedge MHZ48);
    if (nRESET) model_edge();
    @(negedge MHZ48);
    compare();
    rel++;
    if (!nE && !p_e)  e_rise.push_back(rel);
    if (nE && p_e)    e_fall.push_back(rel);
    if (!nQ && !p_q)  q_rise.push_back(rel);
    if (nQ && p_q)    q_fall.push_back(rel);
    if (MHZ12 && !p_m) m_rise.push_back(rel);
    if (CYCSTART)     cys_q.push_back(rel);
    if (STRETCHING)   str_cnt++;
    if (WAITTO)       wto_cnt++;
    p_e = ~nE;
    p_q = ~nQ;
    p_m = MHZ12;
  endtask

  task automatic do_reset(input int n);
    nRESET = 1'b0;
    model_reset();
    #1;
    compare();
    repeat (n) step();
    nRESET = 1'b1;
    clr_stats();
  endtask

  task automatic sync_to_cycle();
    nWAIT = '1;
    for (int i = 0; (i < 200) && (pos != 0); i++) step();
    clr_stats();
  endtask

  // Free-running start-up sequence straight after reset release.
  task automatic check_t1(input string tag);
    nWAIT = '1;
    repeat (32) step();
    chk({tag, " CYCSTART first edge"}, cys_q[0], 1);
    chk({tag, " Q rise edge"},  q_rise[0], 4);
    chk({tag, " E rise edge"},  e_rise[0], 8);
    chk({tag, " Q fall edge"},  q_fall[0], 12);
    chk({tag, " E fall edge"},  e_fall[0], 16);
    chk({tag, " E period"},     e_rise[1] - e_rise[0], 16);
    chk({tag, " MHZ12 first rise"}, m_rise[0], 2);
    chk({tag, " MHZ12 period"}, m_rise[1] - m_rise[0], 4);
    chk({tag, " no STRETCHING"}, str_cnt, 0);
  endtask

  initial begin
    #2;
    do_reset(3);
    check_t1("t1");

    // Two sampled P3 terminal counts with nWAIT[0] low.
    sync_to_cycle();
    for (int i = 1; i <= 32; i++) begin
      nWAIT = (i >= 13 && i <= 20) ? 2'b10 : 2'b11;
      step();
    end
    chk("t2 E high length", e_fall[0] - e_rise[0], 16);
    chk("t2 STRETCHING cycles", str_cnt, 8);
    chk("t2 WAITTO count", wto_cnt, 0);

    // nWAIT[1] held low: stretch saturates every cycle.
    sync_to_cycle();
    nWAIT = 2'b01;
    repeat (96) step();
    chk("t3 E high length #1", e_fall[0] - e_rise[0], 40);
    chk("t3 E high length #2", e_fall[1] - e_rise[1], 40);
    chk("t3 WAITTO count", wto_cnt, 2);
    chk("t3 STRETCHING cycles", str_cnt, 64);

    // Requests only in P0/P1 never stretch.
    sync_to_cycle();
    for (int i = 1; i <= 32; i++) begin
      nWAIT = (((i - 1) % 16) < 8) ? 2'b00 : 2'b11;
      step();
    end
    chk("t4 E period", e_rise[1] - e_rise[0], 16);
    chk("t4 E high length", e_fall[0] - e_rise[0], 8);
    chk("t4 STRETCHING cycles", str_cnt, 0);

    // Pulse around the P3 terminal count.
    sync_to_cycle();
    for (int i = 1; i <= 32; i++) begin
      nWAIT = (i == 16 || i == 17) ? 2'b10 : 2'b11;
      step();
    end
`ifdef EQCLK_WAIT_SYNC_EN
    chk("t6a E high length", e_fall[0] - e_rise[0], 8);
`else
    chk("t6a E high length", e_fall[0] - e_rise[0], 12);
`endif

    // Pulse ending two cycles before the P3 terminal count.
    sync_to_cycle();
    for (int i = 1; i <= 32; i++) begin
      nWAIT = (i >= 5 && i <= 14) ? 2'b10 : 2'b11;
      step();
    end
`ifdef EQCLK_WAIT_SYNC_EN
    chk("t6b E high length", e_fall[0] - e_rise[0], 12);
`else
    chk("t6b E high length", e_fall[0] - e_rise[0], 8);
`endif

    // Reset during the third inserted quarter.
    sync_to_cycle();
    nWAIT = 2'b10;
    repeat (25) step();
    chk("t5 STRETCHING before reset", {31'd0, STRETCHING}, 1);
    nRESET = 1'b0;
    model_reset();
    #1;
    chk6("t5 outputs in reset", {MHZ12, nQ, nE, CYCSTART, STRETCHING, WAITTO}, 6'b011000);
    nWAIT = '1;
    #1;
    do_reset(2);
    check_t1("t5 restart");

    // Randomized wait traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)
        nWAIT = ($urandom_range(0, 1) == 1) ? '1 : N_WAIT'($urandom);
      if ($urandom_range(0, 999) == 0)
        do_reset($urandom_range(1, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule

`default_nettype wire
